// File: rtl/calc_sequencer_if.sv
// Bundle between the calculator stage sequencer and its surroundings: buttons,
// the calculation-unit handshake, data-collector enables and display selects.
interface calc_sequencer_if;
  logic       previous_stage_button;
  logic       next_stage_button;
  logic       calc_done;
  logic       store_num1;
  logic       store_num2;
  logic       store_operation;
  logic       calc_start;
  logic       display_16bit_switches;
  logic       display_operation;
  logic       display_32bit_answer;
  logic [2:0] stage;
  logic       error;

  modport master (
    output previous_stage_button, next_stage_button, calc_done,
    input  store_num1, store_num2, store_operation, calc_start,
           display_16bit_switches, display_operation, display_32bit_answer,
           stage, error
  );

  modport slave (
    input  previous_stage_button, next_stage_button, calc_done,
    output store_num1, store_num2, store_operation, calc_start,
           display_16bit_switches, display_operation, display_32bit_answer,
           stage, error
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator stage sequencer: debounced prev/next buttons step NUM1/NUM2/OP/CALC/ANS/ERR.
// Optional feature: define SEQ_AUTO_RETURN_EN to return from ANS to NUM1 after an idle period.
module calc_sequencer #(
  parameter int DEBOUNCE_CYCLES    = 1000000,
  parameter int CALC_TIMEOUT       = 64,
  parameter int AUTO_RETURN_CYCLES = 500000000
) (
  input  logic             clk,
  input  logic             rst,
  calc_sequencer_if.slave  bus
);

  localparam logic [2:0] S_NUM1 = 3'd0;
  localparam logic [2:0] S_NUM2 = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_ANS  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = $clog2(DEBOUNCE_CYCLES + 4);
  localparam int TO_W = $clog2(CALC_TIMEOUT + 1);

  // Bit 0 is the previous-stage button, bit 1 the next-stage button.
  logic [1:0]           raw_btn;
  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           deb_q, deb_d;
  logic [1:0]           deb_prev_q, deb_prev_d;
  logic [1:0]           press_q, press_d;
  logic [1:0]           armed_q, armed_d;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [ST_W-1:0]      settle_cnt_q, settle_cnt_d;
  logic                 settle_done_q, settle_done_d;

  logic [2:0]           state_q, state_d;
  logic                 calc_first_q, calc_first_d;
  logic [TO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                 prev_only, next_only;

  assign raw_btn = {bus.next_stage_button, bus.previous_stage_button};

  // Settling window after reset: a button only arms once its debounced level has
  // been seen low after the window, so a button held through reset never fires.
  always_comb begin
    settle_cnt_d  = settle_cnt_q;
    settle_done_d = settle_done_q;
    if (!settle_done_q) begin
      settle_cnt_d = settle_cnt_q + 1'b1;
      if (settle_cnt_q == ST_W'(DEBOUNCE_CYCLES + 2)) begin
        settle_done_d = 1'b1;
      end
    end
  end

  always_comb begin
    sync1_d    = raw_btn;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    db_cnt_d   = '0;
    armed_d    = armed_q;
    press_d    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
      armed_d[i] = armed_q[i] | (settle_done_q & ~deb_q[i]);
      press_d[i] = armed_q[i] & deb_q[i] & ~deb_prev_q[i];
    end
  end

  assign prev_only = press_q[0] & ~press_q[1];
  assign next_only = press_q[1] & ~press_q[0];

`ifdef SEQ_AUTO_RETURN_EN
  localparam int AR_W = $clog2(AUTO_RETURN_CYCLES + 1);
  logic [AR_W-1:0] ar_cnt_q, ar_cnt_d;
`else
  logic unused_auto_return;
  assign unused_auto_return = (AUTO_RETURN_CYCLES != 0);
`endif

  // Stage FSM; CALC ignores buttons and leaves only on calc_done or timeout.
  always_comb begin
    state_d      = state_q;
    calc_first_d = 1'b0;
    tmo_cnt_d    = tmo_cnt_q;
`ifdef SEQ_AUTO_RETURN_EN
    ar_cnt_d     = '0;
`endif
    case (state_q)
      S_NUM1: begin
        if (next_only) state_d = S_NUM2;
      end
      S_NUM2: begin
        if (next_only)      state_d = S_OP;
        else if (prev_only) state_d = S_NUM1;
      end
      S_OP: begin
        if (next_only) begin
          state_d      = S_CALC;
          calc_first_d = 1'b1;
          tmo_cnt_d    = '0;
        end else if (prev_only) begin
          state_d = S_NUM2;
        end
      end
      S_CALC: begin
        if (bus.calc_done) begin
          state_d = S_ANS;
        end else if (tmo_cnt_q == TO_W'(CALC_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_ANS: begin
        if (next_only)      state_d = S_NUM1;
        else if (prev_only) state_d = S_OP;
`ifdef SEQ_AUTO_RETURN_EN
        if (press_q == 2'b00) begin
          if (ar_cnt_q == AR_W'(AUTO_RETURN_CYCLES - 1)) begin
            state_d = S_NUM1;
          end else begin
            ar_cnt_d = ar_cnt_q + 1'b1;
          end
        end
`endif
      end
      S_ERR: begin
        if (next_only || prev_only) state_d = S_NUM1;
      end
      default: state_d = S_NUM1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      deb_q         <= '0;
      deb_prev_q    <= '0;
      press_q       <= '0;
      armed_q       <= '0;
      db_cnt_q      <= '0;
      settle_cnt_q  <= '0;
      settle_done_q <= 1'b0;
      state_q       <= S_NUM1;
      calc_first_q  <= 1'b0;
      tmo_cnt_q     <= '0;
`ifdef SEQ_AUTO_RETURN_EN
      ar_cnt_q      <= '0;
`endif
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_q         <= deb_d;
      deb_prev_q    <= deb_prev_d;
      press_q       <= press_d;
      armed_q       <= armed_d;
      db_cnt_q      <= db_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      settle_done_q <= settle_done_d;
      state_q       <= state_d;
      calc_first_q  <= calc_first_d;
      tmo_cnt_q     <= tmo_cnt_d;
`ifdef SEQ_AUTO_RETURN_EN
      ar_cnt_q      <= ar_cnt_d;
`endif
    end
  end

  assign bus.stage                  = state_q;
  assign bus.calc_start             = calc_first_q;
  assign bus.store_num1             = (state_q == S_NUM1);
  assign bus.store_num2             = (state_q == S_NUM2);
  assign bus.store_operation        = (state_q == S_OP);
  assign bus.display_16bit_switches = (state_q == S_NUM1) || (state_q == S_NUM2);
  assign bus.display_operation      = (state_q == S_OP);
  assign bus.display_32bit_answer   = (state_q == S_ANS);
  assign bus.error                  = (state_q == S_ERR);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with DEBOUNCE_CYCLES=4, CALC_TIMEOUT=8, AUTO_RETURN_CYCLES=16.
// Press-to-stage latency with these settings is 8 clock edges after the raw button change.
module tb_calc_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  calc_sequencer_if bus_if ();

  calc_sequencer #(
    .DEBOUNCE_CYCLES   (4),
    .CALC_TIMEOUT      (8),
    .AUTO_RETURN_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic prev_btn, input logic next_btn, input logic done);
    bus_if.previous_stage_button = prev_btn;
    bus_if.next_stage_button     = next_btn;
    bus_if.calc_done             = done;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hold a button long enough to register one press, then release until it debounces low.
  task automatic pressButton(input logic is_next);
    applyStimulus(!is_next, is_next, 1'b0);
    tick(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(8);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("reset_stage", {29'd0, bus_if.stage}, 32'd0);
    checkOutput("reset_store_num1", {31'd0, bus_if.store_num1}, 32'd1);
    checkOutput("reset_disp16", {31'd0, bus_if.display_16bit_switches}, 32'd1);
    checkOutput("reset_calc_start", {31'd0, bus_if.calc_start}, 32'd0);
    checkOutput("reset_error", {31'd0, bus_if.error}, 32'd0);
    checkOutput("reset_disp32", {31'd0, bus_if.display_32bit_answer}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(12);

    $display("[TB] calc_done outside CALC");
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(3);
    checkOutput("done_in_num1", {29'd0, bus_if.stage}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);

    $display("[TB] clean walk to ANS");
    pressButton(1'b1);
    checkOutput("walk_num2", {29'd0, bus_if.stage}, 32'd1);
    checkOutput("walk_store_num2", {31'd0, bus_if.store_num2}, 32'd1);
    checkOutput("walk_disp16_num2", {31'd0, bus_if.display_16bit_switches}, 32'd1);
    pressButton(1'b1);
    checkOutput("walk_op", {29'd0, bus_if.stage}, 32'd2);
    checkOutput("walk_store_op", {31'd0, bus_if.store_operation}, 32'd1);
    checkOutput("walk_disp_op", {31'd0, bus_if.display_operation}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(7);
    checkOutput("latency_before", {29'd0, bus_if.stage}, 32'd2);
    tick(1);
    checkOutput("calc_entry", {29'd0, bus_if.stage}, 32'd3);
    checkOutput("calc_start_first", {31'd0, bus_if.calc_start}, 32'd1);
    checkOutput("calc_outputs_zero", {24'd0, bus_if.store_num1, bus_if.store_num2,
                bus_if.store_operation, bus_if.display_16bit_switches, bus_if.display_operation,
                bus_if.display_32bit_answer, bus_if.error, 1'b0}, 32'd0);
    tick(1);
    checkOutput("calc_start_second", {31'd0, bus_if.calc_start}, 32'd0);
    tick(2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("calc_wait", {29'd0, bus_if.stage}, 32'd3);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ans_stage", {29'd0, bus_if.stage}, 32'd4);
    checkOutput("ans_disp32", {31'd0, bus_if.display_32bit_answer}, 32'd1);

`ifdef SEQ_AUTO_RETURN_EN
    $display("[TB] auto-return from ANS");
    tick(15);
    checkOutput("auto_before", {29'd0, bus_if.stage}, 32'd4);
    tick(1);
    checkOutput("auto_return", {29'd0, bus_if.stage}, 32'd0);
`else
    $display("[TB] ANS held while idle");
    tick(100);
    checkOutput("ans_hold", {29'd0, bus_if.stage}, 32'd4);
    pressButton(1'b1);
    checkOutput("ans_next_wrap", {29'd0, bus_if.stage}, 32'd0);
`endif
    tick(4);

    $display("[TB] late calc_done, next press in ANS");
    pressButton(1'b1);
    pressButton(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(8);
    checkOutput("calc2_entry", {29'd0, bus_if.stage}, 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(6);
    checkOutput("calc2_wait", {29'd0, bus_if.stage}, 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("calc2_ans", {29'd0, bus_if.stage}, 32'd4);
    pressButton(1'b1);
    checkOutput("ans_next_to_num1", {29'd0, bus_if.stage}, 32'd0);

    $display("[TB] calc timeout");
    pressButton(1'b1);
    pressButton(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(8);
    checkOutput("calc3_entry", {29'd0, bus_if.stage}, 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(7);
    checkOutput("timeout_before", {29'd0, bus_if.stage}, 32'd3);
    tick(1);
    checkOutput("timeout_err", {29'd0, bus_if.stage}, 32'd5);
    checkOutput("timeout_error_out", {31'd0, bus_if.error}, 32'd1);
    tick(4);
    pressButton(1'b0);
    checkOutput("err_prev", {29'd0, bus_if.stage}, 32'd0);

    $display("[TB] simultaneous presses and NUM1 floor");
    pressButton(1'b1);
    pressButton(1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(8);
    checkOutput("both_in_op", {29'd0, bus_if.stage}, 32'd2);
    pressButton(1'b0);
    checkOutput("op_prev", {29'd0, bus_if.stage}, 32'd1);
    pressButton(1'b0);
    checkOutput("num2_prev", {29'd0, bus_if.stage}, 32'd0);
    pressButton(1'b0);
    checkOutput("num1_prev_floor", {29'd0, bus_if.stage}, 32'd0);

    $display("[TB] bounce rejection");
    applyStimulus(1'b0, 1'b1, 1'b0); tick(3);
    applyStimulus(1'b0, 1'b0, 1'b0); tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0); tick(2);
    applyStimulus(1'b0, 1'b0, 1'b0); tick(2);
    applyStimulus(1'b0, 1'b1, 1'b0); tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0); tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0); tick(3);
    applyStimulus(1'b0, 1'b0, 1'b0); tick(12);
    checkOutput("bounce_no_change", {29'd0, bus_if.stage}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(12);
    checkOutput("held_one_advance", {29'd0, bus_if.stage}, 32'd1);

    $display("[TB] reset during CALC with next held");
    pressButton(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(8);
    checkOutput("calc4_entry", {29'd0, bus_if.stage}, 32'd3);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_stage", {29'd0, bus_if.stage}, 32'd0);
    checkOutput("rst_async_start", {31'd0, bus_if.calc_start}, 32'd0);
    checkOutput("rst_async_num1", {31'd0, bus_if.store_num1}, 32'd1);
    tick(2);
    rst = 1'b0;
    tick(30);
    checkOutput("held_through_rst", {29'd0, bus_if.stage}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(10);
    checkOutput("release_no_press", {29'd0, bus_if.stage}, 32'd0);
    pressButton(1'b1);
    checkOutput("repress_after_rst", {29'd0, bus_if.stage}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
